// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared pipeline definitions for stage-boundary blocks and their benches.
//   skid_state_t       : occupancy of a two-entry elastic register
//                        (EMPTY = nothing held, BUSY = main only,
//                         FULL = main + skid)
//   DEFAULT_DATA_WIDTH : default payload width across a stage boundary
// ---------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_if
// Valid/ready stage-boundary bundle with flush.
//   i_valid/i_data/o_ready : upstream handshake (payload into the block)
//   o_valid/o_data/i_ready : downstream handshake (payload out of the block)
//   i_flush                : squash everything held by the block
// Modports:
//   slave  : the pipeline register itself
//   master : whatever drives/consumes it (neighbouring stages or a bench)
// ---------------------------------------------------------------------------
interface pipe_skid_reg_if
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_ready;
    logic                  i_flush;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        input  i_flush,
        output o_ready,
        output o_valid,
        output o_data
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        output i_flush,
        input  o_ready,
        input  o_valid,
        input  o_data
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry elastic pipeline register. Absorbs one cycle of downstream
// back-pressure so that o_ready never depends combinationally on i_ready.
// A synchronous flush empties the block without touching the data registers.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (beats flush and handshakes)
//   bus  : pipe_skid_reg_if.slave (valid/ready in, valid/ready out, flush)
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_skid_reg_if.slave       bus
);

    skid_state_t           state_reg;
    skid_state_t           state_next;
    logic [DATA_WIDTH-1:0] main_reg;
    logic [DATA_WIDTH-1:0] main_next;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic [DATA_WIDTH-1:0] skid_next;
    logic                  valid_reg;
    logic                  ready_reg;

    logic                  in_fire;
    logic                  out_fire;

    // Handshake flags come only from registered state, so there is no
    // combinational path from i_valid/i_ready to o_ready/o_valid.
    assign in_fire  = bus.i_valid & ready_reg;
    assign out_fire = valid_reg & bus.i_ready;

    assign bus.o_valid = valid_reg;
    assign bus.o_ready = ready_reg;
    assign bus.o_data  = main_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;

        unique case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    main_next  = bus.i_data;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_next = bus.i_data;
                end else if (in_fire) begin
                    // Downstream stalled: park the newer payload behind main.
                    skid_next  = bus.i_data;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_next  = skid_reg;
                    state_next = BUSY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Squash: drop occupancy only; data registers keep their contents
        // since o_valid = 0 tells downstream to ignore o_data.
        if (bus.i_flush) begin
            state_next = EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            // Output flags are registered copies of the decoded next state.
            valid_reg <= (state_next != EMPTY);
            ready_reg <= (state_next != FULL);
        end
    end

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------
    a_no_in_fire_full : assert property (@(posedge clk) disable iff (rst)
        (state_reg == FULL) |-> !in_fire);

    a_out_stable : assert property (@(posedge clk) disable iff (rst)
        (valid_reg && !bus.i_ready && !bus.i_flush) |=>
            (valid_reg && $stable(main_reg)));

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        state_reg inside {EMPTY, BUSY, FULL});

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed bench for pipe_skid_reg. Inputs change 1 ns after each rising
// edge; outputs are sampled at that same point, which is safe because every
// output is registered.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;
    import pipe_skid_reg_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_acc;
    int   n_dlv;

    pipe_skid_reg_if #(.DATA_WIDTH(32)) bus ();

    pipe_skid_reg #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        bus.i_flush = f;
    endtask

    // Advance one edge; counts handshakes seen just before the edge.
    task automatic step();
        if (bus.i_valid && bus.o_ready) n_acc++;
        if (bus.o_valid && bus.i_ready) n_dlv++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_acc = 0;
        n_dlv = 0;
        rst   = 1'b1;
        drive(1'b1, 32'hFF, 1'b1, 1'b0);

        // ---- reset (payload offered during reset must not be captured)
        step();
        step();
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_data",  bus.o_data,           32'd0);
        rst = 1'b0;

        // ---- reset then stream
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        check("str_ready0", {31'd0, bus.o_ready}, 32'd1);
        step();
        check("str_d11", bus.o_data, 32'h11);
        check("str_v11", {31'd0, bus.o_valid}, 32'd1);
        check("str_ready1", {31'd0, bus.o_ready}, 32'd1);
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        step();
        check("str_d22", bus.o_data, 32'h22);
        check("str_ready2", {31'd0, bus.o_ready}, 32'd1);
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        step();
        check("str_d33", bus.o_data, 32'h33);
        check("str_ready3", {31'd0, bus.o_ready}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("str_vend", {31'd0, bus.o_valid}, 32'd0);

        // ---- single stall
        drive(1'b1, 32'hA0, 1'b1, 1'b0);
        step();
        check("ss_dA0", bus.o_data, 32'hA0);
        drive(1'b1, 32'hA1, 1'b1, 1'b0);
        step();
        check("ss_dA1", bus.o_data, 32'hA1);
        drive(1'b1, 32'hA2, 1'b0, 1'b0);
        step();
        check("ss_full_ready", {31'd0, bus.o_ready}, 32'd0);
        check("ss_hold_dA1", bus.o_data, 32'hA1);
        check("ss_hold_v", {31'd0, bus.o_valid}, 32'd1);
        drive(1'b1, 32'hA3, 1'b1, 1'b0);   // offered, not taken (o_ready = 0)
        step();
        check("ss_dA2", bus.o_data, 32'hA2);
        check("ss_ready_back", {31'd0, bus.o_ready}, 32'd1);
        drive(1'b1, 32'hA3, 1'b1, 1'b0);
        step();
        check("ss_dA3", bus.o_data, 32'hA3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("ss_vend", {31'd0, bus.o_valid}, 32'd0);

        // ---- long stall: upstream holds each payload until accepted
        n_acc = 0;
        begin
            logic [31:0] d;
            d = 32'hB0;
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, d, 1'b0, 1'b0);
                if (bus.o_ready) d = d + 32'd1;
                step();
                check($sformatf("ls_hold%0d", i), bus.o_data, 32'hB0);
            end
        end
        check("ls_accepted", n_acc, 32'd2);
        check("ls_ready", {31'd0, bus.o_ready}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("ls_dB1", bus.o_data, 32'hB1);
        check("ls_vB1", {31'd0, bus.o_valid}, 32'd1);
        step();
        check("ls_vend", {31'd0, bus.o_valid}, 32'd0);

        // ---- flush in FULL
        drive(1'b1, 32'h5A, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h5B, 1'b0, 1'b0);
        step();
        check("fl_full_ready", {31'd0, bus.o_ready}, 32'd0);
        check("fl_d5A", bus.o_data, 32'h5A);
        drive(1'b1, 32'h5C, 1'b0, 1'b1);
        step();
        check("fl_valid", {31'd0, bus.o_valid}, 32'd0);
        check("fl_ready", {31'd0, bus.o_ready}, 32'd1);
        check("fl_data_kept", bus.o_data, 32'h5A);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("fl_no5C", {31'd0, bus.o_valid}, 32'd0);

        // ---- flush with consumption
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        step();
        check("fc_d77", bus.o_data, 32'h77);
        n_dlv = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        check("fc_empty", {31'd0, bus.o_valid}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("fc_delivered", n_dlv, 32'd1);
        check("fc_ready", {31'd0, bus.o_ready}, 32'd1);

        // ---- reset mid-operation while FULL
        drive(1'b1, 32'hC1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC2, 1'b0, 1'b0);
        step();
        check("rm_full", {31'd0, bus.o_ready}, 32'd0);
        rst = 1'b1;
        drive(1'b1, 32'hEE, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        check("rm_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rm_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rm_data", bus.o_data, 32'd0);
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        step();
        check("rm_d99", bus.o_data, 32'h99);
        check("rm_v99", {31'd0, bus.o_valid}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("rm_alone", {31'd0, bus.o_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
